// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch and data ports with RMW partial stores
module mem_arbiter #(
  parameter int RAM_AW     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RDATA, RMW, WR, NOP, ERR} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [2:0]        starve_q, starve_d;
  logic              gnt_dm, gnt_if, oor, done;
  logic [31:0]       req_addr, merged;
  logic              unused_bits;
  assign unused_bits = ^req_addr[1:0];
  // state and transaction latches; owner_q=1 means the data port owns the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      starve_q <= starve_d;
    end
  end
  // arbitration with fetch starvation guard, routing and next state
  always_comb begin
    gnt_dm   = state_q == IDLE && dm_req && !(if_req && starve_q == 3'(STARVE_MAX));
    gnt_if   = state_q == IDLE && if_req && !gnt_dm;
    req_addr = gnt_dm ? dm_addr : if_addr;
    oor      = |req_addr[31:RAM_AW+2];
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    starve_d = starve_q;
    state_d  = state_q == RD ? RDATA : state_q == RMW ? WR : IDLE;
    if (state_q == IDLE) begin
      starve_d = (gnt_if || !if_req) ? 3'd0
               : (gnt_dm && starve_q != 3'(STARVE_MAX)) ? starve_q + 3'd1 : starve_q;
      if (gnt_dm || gnt_if) begin
        owner_d = gnt_dm;
        addr_d  = req_addr[RAM_AW+1:2];
        we_d    = gnt_dm && dm_we;
        wdata_d = gnt_dm ? dm_wdata : 32'd0;
        wstrb_d = gnt_dm ? dm_wstrb : 4'd0;
        state_d = oor ? ERR : !we_d ? RD : wstrb_d == 4'hf ? WR : wstrb_d == 4'h0 ? NOP : RMW;
      end
    end
  end
  // byte merge of store data over the word read back during RMW
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
  end
  // outputs decoded from registered state only
  always_comb begin
    done      = state_q inside {RDATA, WR, NOP, ERR};
    ram_en    = state_q inside {RD, RMW, WR};
    ram_we    = state_q == WR && we_q;
    ram_addr  = ram_en ? addr_q : '0;
    ram_wdata = ram_we ? merged : 32'd0;
    if_ack    = done && !owner_q;
    dm_ack    = done && owner_q;
    if_err    = state_q == ERR && !owner_q;
    dm_err    = state_q == ERR && owner_q;
    if_rdata  = (state_q == RDATA && !owner_q) ? ram_rdata : 32'd0;
    dm_rdata  = (state_q == RDATA && owner_q) ? ram_rdata : 32'd0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, RMW, errors and reset abort
module tb_mem_arbiter;
  logic        clk, rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:16383];
  logic        any_out;
  int          n_chk = 0, n_err = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  assign any_out = |{if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
                     ram_en, ram_we, ram_addr, ram_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_set(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; dm_wstrb = s;
  endtask

  initial begin
    int dm_run, ifs, acks;
    mem[5] <= 32'hDEADBEEF;
    mem[2] <= 32'h11223344;
    mem[3] <= 32'h55555555;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h14;
    dm_set(1'b0, 32'h14, 32'h0, 4'h0);
    tick(); tick();
    check("rst_outs_zero", any_out, 0);
    rst = 1'b1;
    tick();
    check("ld_ram_en", ram_en, 1);
    check("ld_ram_we", ram_we, 0);
    check("ld_ram_addr", ram_addr, 5);
    check("ld_no_early_ack", dm_ack, 0);
    tick();
    check("ld_ack", dm_ack, 1);
    check("ld_rdata", dm_rdata, 32'hDEADBEEF);
    dm_req = 1'b0;
    tick();
    check("idle_outs_zero", any_out, 0);

    dm_set(1'b1, 32'h09, 32'h0000AA00, 4'b0010);
    tick();
    check("rmw_rd_en", ram_en, 1);
    check("rmw_rd_we", ram_we, 0);
    check("rmw_rd_addr", ram_addr, 2);
    check("rmw_no_ack", dm_ack, 0);
    tick();
    check("rmw_wr_we", ram_we, 1);
    check("rmw_wdata", ram_wdata, 32'h1122AA44);
    check("rmw_ack", dm_ack, 1);
    dm_req = 1'b0;
    tick();
    check("rmw_mem", mem[2], 32'h1122AA44);

    dm_set(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    tick();
    check("st_ack", dm_ack, 1);
    check("st_we", ram_we, 1);
    check("st_addr", ram_addr, 4);
    check("st_wdata", ram_wdata, 32'hCAFEF00D);
    dm_req = 1'b0;
    tick();
    check("st_mem", mem[4], 32'hCAFEF00D);

    dm_set(1'b1, 32'h18, 32'h12345678, 4'h0);
    tick();
    check("nop_ack", dm_ack, 1);
    check("nop_no_ram", ram_en, 0);
    dm_req = 1'b0;
    tick();

    dm_set(1'b0, 32'h00010000, 32'h0, 4'h0);
    tick();
    check("err_ack", dm_ack, 1);
    check("err_flag", dm_err, 1);
    check("err_rdata", dm_rdata, 0);
    check("err_no_ram", ram_en, 0);
    dm_req = 1'b0;
    tick();

    if_req = 1'b1; if_addr = 32'h17;
    tick();
    check("if_ram_addr", ram_addr, 5);
    check("if_no_early_ack", if_ack, 0);
    tick();
    check("if_ack", if_ack, 1);
    check("if_rdata", if_rdata, 32'hDEADBEEF);
    check("if_dm_quiet", dm_ack, 0);
    if_req = 1'b0;
    tick();

    if_req = 1'b1; if_addr = 32'h80000000;
    tick();
    check("if_err_ack", if_ack, 1);
    check("if_err_flag", if_err, 1);
    check("if_err_no_ram", ram_en, 0);
    if_req = 1'b0;
    tick();

    if_req = 1'b1; if_addr = 32'h08;
    dm_set(1'b0, 32'h10, 32'h0, 4'h0);
    dm_run = 0; ifs = 0;
    for (int c = 0; c < 100 && ifs < 3; c++) begin
      tick();
      if (dm_ack) begin
        dm_run++;
        check("col_dm_rdata", dm_rdata, 32'hCAFEF00D);
      end
      if (if_ack) begin
        check("col_dm_between_if", dm_run, 4);
        check("col_if_rdata", if_rdata, 32'h1122AA44);
        dm_run = 0;
        ifs++;
        if (ifs == 3) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
    end
    check("col_if_grants", ifs, 3);
    tick();

    dm_set(1'b1, 32'h0C, 32'h0000FFFF, 4'b0011);
    tick();
    check("abort_rmw_rd", ram_en, 1);
    rst = 1'b0;
    #1;
    check("abort_outs_zero", any_out, 0);
    dm_req = 1'b0;
    acks = 0;
    tick(); acks += int'(dm_ack) + int'(if_ack);
    rst = 1'b1;
    tick(); acks += int'(dm_ack) + int'(if_ack);
    tick(); acks += int'(dm_ack) + int'(if_ack);
    check("abort_no_ack", acks, 0);
    check("abort_idle_zero", any_out, 0);
    check("abort_mem", mem[3], 32'h55555555);
    dm_set(1'b0, 32'h0C, 32'h0, 4'h0);
    tick(); tick();
    check("post_abort_ack", dm_ack, 1);
    check("post_abort_rdata", dm_rdata, 32'h55555555);
    dm_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
